// File: rtl/execute_if.sv
// Decoded micro-op bus into the execute stage plus its branch/flush outputs.
interface execute_if;
  logic        num_to_rhs;
  logic [31:0] num;
  logic [3:0]  sel_p0;
  logic [3:0]  sel_p1;
  logic [3:0]  sel_in;
  logic [4:0]  uop;
  logic [3:0]  branch_cond;
  logic        global_disable;
  logic [31:0] delta_instruction;

  modport master (
    output num_to_rhs, num, sel_p0, sel_p1, sel_in, uop, branch_cond,
    input  global_disable, delta_instruction
  );

  modport slave (
    input  num_to_rhs, num, sel_p0, sel_p1, sel_in, uop, branch_cond,
    output global_disable, delta_instruction
  );
endinterface

// File: rtl/execute.sv
// Execute stage: register file, NZCV flags, data memory, branch evaluation and flush.
// Optional macro EXECUTE_ASR_EN enables uop 13 as arithmetic shift right.
module execute #(
  parameter int unsigned MEM_WORDS    = 64,
  parameter int unsigned BRANCH_FLUSH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  execute_if.slave bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SHW   = $clog2(XLEN);
  localparam int unsigned NREGS = 16;
  localparam int unsigned AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CW    = $clog2(BRANCH_FLUSH + 1);

  localparam logic [4:0] UOP_ADD = 5'd1;
  localparam logic [4:0] UOP_SUB = 5'd2;
  localparam logic [4:0] UOP_AND = 5'd3;
  localparam logic [4:0] UOP_EOR = 5'd4;
  localparam logic [4:0] UOP_CMP = 5'd5;
  localparam logic [4:0] UOP_LSL = 5'd6;
  localparam logic [4:0] UOP_LSR = 5'd7;
  localparam logic [4:0] UOP_MOV = 5'd8;
  localparam logic [4:0] UOP_STR = 5'd9;
  localparam logic [4:0] UOP_LDR = 5'd10;
  localparam logic [4:0] UOP_ORR = 5'd11;
`ifdef EXECUTE_ASR_EN
  localparam logic [4:0] UOP_ASR = 5'd13;
`endif

  // Flag vector layout {N, Z, C, V}
  localparam int unsigned FN = 3;
  localparam int unsigned FZ = 2;
  localparam int unsigned FC = 1;
  localparam int unsigned FV = 0;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] mem_q  [MEM_WORDS];
  logic [3:0]      flags_q, flags_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gd_q, gd_d;
  logic [XLEN-1:0] delta_q, delta_d;

  logic [XLEN-1:0] p0, p1, rhs, shamt, diff, addr_sum, mem_rdata;
  logic [XLEN-1:0] shl, shr, wr_data;
  logic [AW-1:0]   mem_addr;
  logic            rf_we, flag_we, mem_we, cond_true, taken;
`ifdef EXECUTE_ASR_EN
  logic [XLEN-1:0] sra;
`endif

  // Operand fetch, shifter and memory address
  always_comb begin
    p0        = regs_q[bus.sel_p0];
    p1        = regs_q[bus.sel_p1];
    rhs       = bus.num_to_rhs ? bus.num : p1;
    shamt     = bus.num_to_rhs ? bus.num : p0;
    diff      = p0 - rhs;
    shl       = (shamt > XLEN'(XLEN - 1)) ? '0 : (p1 << shamt[SHW-1:0]);
    shr       = (shamt > XLEN'(XLEN - 1)) ? '0 : (p1 >> shamt[SHW-1:0]);
`ifdef EXECUTE_ASR_EN
    sra       = (shamt > XLEN'(XLEN - 1)) ? {XLEN{p1[XLEN-1]}}
                                          : XLEN'($signed(p1) >>> shamt[SHW-1:0]);
`endif
    addr_sum  = p1 + (bus.num_to_rhs ? bus.num : '0);
    mem_addr  = AW'(addr_sum % XLEN'(MEM_WORDS));
    mem_rdata = mem_q[mem_addr];
  end

  // Micro-op decode; every write is squashed while a flush is in progress
  always_comb begin
    rf_we   = 1'b0;
    flag_we = 1'b0;
    mem_we  = 1'b0;
    wr_data = '0;
    flags_d = flags_q;
    case (bus.uop)
      UOP_ADD: begin rf_we = 1'b1; wr_data = p0 + rhs; end
      UOP_SUB: begin rf_we = 1'b1; wr_data = diff; end
      UOP_AND: begin rf_we = 1'b1; wr_data = p0 & rhs; end
      UOP_EOR: begin rf_we = 1'b1; wr_data = p0 ^ rhs; end
      UOP_ORR: begin rf_we = 1'b1; wr_data = p0 | rhs; end
      UOP_LSL: begin rf_we = 1'b1; wr_data = shl; end
      UOP_LSR: begin rf_we = 1'b1; wr_data = shr; end
`ifdef EXECUTE_ASR_EN
      UOP_ASR: begin rf_we = 1'b1; wr_data = sra; end
`endif
      UOP_MOV: begin rf_we = 1'b1; wr_data = bus.num_to_rhs ? bus.num : p0; end
      UOP_LDR: begin rf_we = 1'b1; wr_data = mem_rdata; end
      UOP_STR: mem_we = 1'b1;
      UOP_CMP: begin
        flag_we     = 1'b1;
        flags_d[FN] = diff[XLEN-1];
        flags_d[FZ] = (diff == '0);
        flags_d[FC] = (p0 >= rhs);
        flags_d[FV] = (p0[XLEN-1] ^ rhs[XLEN-1]) & (diff[XLEN-1] ^ p0[XLEN-1]);
      end
      default: ;
    endcase
    if (gd_q) begin
      rf_we   = 1'b0;
      flag_we = 1'b0;
      mem_we  = 1'b0;
    end
    if (!flag_we) flags_d = flags_q;
  end

  // ARM condition codes on the current flags
  always_comb begin
    cond_true = 1'b0;
    case (bus.branch_cond)
      4'd0:  cond_true = flags_q[FZ];
      4'd1:  cond_true = !flags_q[FZ];
      4'd2:  cond_true = flags_q[FC];
      4'd3:  cond_true = !flags_q[FC];
      4'd4:  cond_true = flags_q[FN];
      4'd5:  cond_true = !flags_q[FN];
      4'd6:  cond_true = flags_q[FV];
      4'd7:  cond_true = !flags_q[FV];
      4'd8:  cond_true = flags_q[FC] && !flags_q[FZ];
      4'd9:  cond_true = !flags_q[FC] || flags_q[FZ];
      4'd10: cond_true = (flags_q[FN] == flags_q[FV]);
      4'd11: cond_true = (flags_q[FN] != flags_q[FV]);
      4'd12: cond_true = !flags_q[FZ] && (flags_q[FN] == flags_q[FV]);
      4'd13: cond_true = flags_q[FZ] || (flags_q[FN] != flags_q[FV]);
      4'd14: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
    taken = cond_true && !gd_q;
  end

  // Flush counter and PC-delta next state
  always_comb begin
    cnt_d   = cnt_q;
    delta_d = '0;
    if (taken) begin
      cnt_d   = CW'(BRANCH_FLUSH);
      delta_d = bus.num;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    gd_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
      gd_q    <= 1'b0;
      delta_q <= '0;
    end else begin
      if (rf_we) regs_q[bus.sel_in] <= wr_data;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      gd_q    <= gd_d;
      delta_q <= delta_d;
    end
  end

  // Data memory has no reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= p0;
  end

  assign bus.global_disable    = gd_q;
  assign bus.delta_instruction = delta_q;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed plan steps, then random micro-ops vs a reference model.
module tb_execute;
  localparam int unsigned MEM_WORDS    = 64;
  localparam int unsigned BRANCH_FLUSH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  execute_if bus();
  execute #(.MEM_WORDS(MEM_WORDS), .BRANCH_FLUSH(BRANCH_FLUSH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [31:0] m_reg [16];
  logic [31:0] m_mem [MEM_WORDS];
  logic        m_n, m_z, m_c, m_v;
  int          m_flush;
  logic [31:0] m_delta;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    {m_n, m_z, m_c, m_v} = 4'b0;
    m_flush = 0;
    m_delta = '0;
  endtask

  function automatic bit cond_holds(input int c);
    case (c)
      0:  return m_z;
      1:  return !m_z;
      2:  return m_c;
      3:  return !m_c;
      4:  return m_n;
      5:  return !m_n;
      6:  return m_v;
      7:  return !m_v;
      8:  return m_c && !m_z;
      9:  return !m_c || m_z;
      10: return m_n == m_v;
      11: return m_n != m_v;
      12: return !m_z && (m_n == m_v);
      13: return m_z || (m_n != m_v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One architectural step on the currently driven instruction
  task automatic model_step();
    logic [31:0] p0, src, b, s, sum, res;
    int unsigned addr;
    longint sd;
    bit active, tk;
    p0     = m_reg[bus.sel_p0];
    src    = m_reg[bus.sel_p1];
    b      = bus.num_to_rhs ? bus.num : src;
    s      = bus.num_to_rhs ? bus.num : p0;
    sum    = src + (bus.num_to_rhs ? bus.num : 32'd0);
    addr   = sum % MEM_WORDS;
    active = (m_flush == 0);
    tk     = active && cond_holds(int'(bus.branch_cond));
    if (active) begin
      case (int'(bus.uop))
        1:  m_reg[bus.sel_in] = p0 + b;
        2:  m_reg[bus.sel_in] = p0 - b;
        3:  m_reg[bus.sel_in] = p0 & b;
        4:  m_reg[bus.sel_in] = p0 ^ b;
        5: begin
          res = p0 - b;
          sd  = longint'($signed(p0)) - longint'($signed(b));
          m_n = res[31];
          m_z = (res == 0);
          m_c = (p0 >= b);
          m_v = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        end
        6:  m_reg[bus.sel_in] = (s >= 32) ? 32'd0 : src << s;
        7:  m_reg[bus.sel_in] = (s >= 32) ? 32'd0 : src >> s;
        8:  m_reg[bus.sel_in] = bus.num_to_rhs ? bus.num : p0;
        9:  m_mem[addr] = p0;
        10: m_reg[bus.sel_in] = m_mem[addr];
        11: m_reg[bus.sel_in] = p0 | b;
`ifdef EXECUTE_ASR_EN
        13: m_reg[bus.sel_in] = (s >= 32) ? {32{src[31]}} : 32'($signed(src) >>> s);
`endif
        default: ;
      endcase
    end
    if (tk) m_flush = BRANCH_FLUSH;
    else if (m_flush > 0) m_flush--;
    m_delta = tk ? bus.num : 32'd0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " gd"}, 32'(bus.global_disable), 32'(m_flush > 0));
    chk({tag, " delta"}, bus.delta_instruction, m_delta);
    chk({tag, " nzcv"}, 32'(dut.flags_q), 32'({m_n, m_z, m_c, m_v}));
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s r%0d", tag, i), dut.regs_q[i], m_reg[i]);
  endtask

  task automatic op(input string tag, input int u, input int rd, input int ra, input int rb,
                    input bit nr, input logic [31:0] n, input int bc);
    bus.uop         = 5'(u);
    bus.sel_in      = 4'(rd);
    bus.sel_p0      = 4'(ra);
    bus.sel_p1      = 4'(rb);
    bus.num_to_rhs  = nr;
    bus.num         = n;
    bus.branch_cond = 4'(bc);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b1;
    bus.uop         = '0;
    bus.sel_in      = '0;
    bus.sel_p0      = '0;
    bus.sel_p1      = '0;
    bus.num_to_rhs  = 1'b0;
    bus.num         = '0;
    bus.branch_cond = 4'hF;
    #2;
    do_reset();

    // Moves and ALU
    op("mov_r1", 8, 1, 0, 0, 1, 32'hCAFE, 15);
    op("mov_r2", 8, 2, 0, 0, 1, 32'hDEAD, 15);
    op("mov_r3", 8, 3, 2, 0, 0, 32'h0, 15);
    chk("plan r1", dut.regs_q[1], 32'h0000CAFE);
    chk("plan r3", dut.regs_q[3], 32'h0000DEAD);
    op("add_r4", 1, 4, 1, 2, 0, 32'h0, 15);
    op("and_r2", 3, 2, 2, 4, 0, 32'h0, 15);
    chk("plan r4", dut.regs_q[4], 32'h0001A9AB);
    chk("plan r2", dut.regs_q[2], 32'h000088A9);

    // Compare and conditional branches
    op("mov_r6", 8, 6, 0, 0, 1, 32'd1, 15);
    op("mov_r7", 8, 7, 0, 0, 1, 32'd1, 15);
    op("cmp", 5, 0, 6, 7, 0, 32'h0, 15);
    chk("plan nzcv", 32'(dut.flags_q), 32'b0110);
    op("br_ne", 0, 0, 0, 0, 0, 32'd5, 1);
    chk("plan ne delta", bus.delta_instruction, 32'd0);
    op("br_eq", 0, 0, 0, 0, 0, 32'd5, 0);
    chk("plan eq delta", bus.delta_instruction, 32'd5);
    op("flush_a", 0, 0, 0, 0, 0, 32'h0, 15);
    op("flush_b", 0, 0, 0, 0, 0, 32'h0, 15);

    // Store / load round trip
    op("str", 9, 0, 1, 6, 1, 32'd28, 15);
    op("ldr", 10, 8, 0, 6, 1, 32'd28, 15);
    chk("plan r8", dut.regs_q[8], 32'h0000CAFE);
    op("nop", 0, 5, 1, 2, 1, 32'h1234, 15);

    // Taken branch squashes the next two instructions
    op("br_al", 0, 0, 0, 0, 0, 32'd10, 14);
    chk("plan al delta", bus.delta_instruction, 32'd10);
    chk("plan al gd", 32'(bus.global_disable), 32'd1);
    op("sq_eor", 4, 1, 1, 3, 0, 32'h0, 14);
    chk("plan sq delta", bus.delta_instruction, 32'd0);
    chk("plan sq r1", dut.regs_q[1], 32'h0000CAFE);
    op("sq_lsl", 6, 9, 0, 8, 1, 32'd8, 15);
    chk("plan sq r9", dut.regs_q[9], 32'd0);
    chk("plan gd off", 32'(bus.global_disable), 32'd0);
    op("post_add", 1, 10, 1, 0, 1, 32'd1, 15);
    chk("plan r10", dut.regs_q[10], 32'h0000CAFF);

    // Reset in the middle of a flush
    op("br_pre_rst", 0, 0, 0, 0, 0, 32'd7, 14);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst gd", 32'(bus.global_disable), 32'd0);
    chk("rst delta", bus.delta_instruction, 32'd0);
    check_all("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every memory word through r1 (r0 stays zero until priming ends)
    for (int a = 0; a < int'(MEM_WORDS); a++) begin
      op("prime_mov", 8, 1, 0, 0, 1, $urandom, 15);
      op("prime_str", 9, 0, 1, 0, 1, 32'(a), 15);
    end

    // Random micro-ops with occasional branches
    for (int k = 0; k < 800; k++) begin
      logic [31:0] n;
      int bc;
      case ($urandom_range(0, 3))
        0: n = 32'($urandom_range(0, 40));
        1: n = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h80000000;
        default: n = $urandom;
      endcase
      bc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 15;
      op("rand", int'($urandom_range(0, 20)), int'($urandom_range(0, 15)),
         int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
         1'($urandom_range(0, 1)), n, bc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
